// File: rtl/kf6845_pkg.sv
// Shared types and helpers for the 6845-compatible CRTC cursor unit.
package kf6845_pkg;

    // Cursor display mode held in R10[6:5].
    typedef enum logic [1:0] {
        NON_BLINK  = 2'b00,
        NO_DISPLAY = 2'b01,
        BLINK16    = 2'b10,
        BLINK32    = 2'b11
    } cursor_mode_t;

    // Field-rate blink gate: the fast mode toggles every 8 fields, the slow mode every 16.
    function automatic logic blink_gate(input cursor_mode_t mode, input logic [4:0] cnt);
        logic gate;
        case (mode)
            NON_BLINK:  gate = 1'b1;
            NO_DISPLAY: gate = 1'b0;
            BLINK16:    gate = ~cnt[3];
            BLINK32:    gate = ~cnt[4];
            default:    gate = 1'b0;
        endcase
        return gate;
    endfunction

endpackage

// File: rtl/kf6845_cursor.sv
// Cursor unit of a 6845-compatible CRTC: cursor start/end and address
// registers, field-rate blink counter and the MA/RA comparator.
module kf6845_cursor
    import kf6845_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        video_clock_enable,
    input  logic [7:0]  internal_data_bus_in,
    output logic [7:0]  internal_data_bus_out,
    input  logic        write_cursor_start_register,
    input  logic        write_cursor_end_register,
    input  logic        write_cursor_h_register,
    input  logic        write_cursor_l_register,
    input  logic        read_cursor_h_register,
    input  logic        read_cursor_l_register,
    input  logic        Horizontal,
    input  logic        Horizontal_End,
    input  logic        V_total,
    input  logic        Scanline_End,
    input  logic [4:0]  RA,
    input  logic [13:0] MA,
    output logic        CURSOR
);

    logic [6:0]   r10_r;        // {mode[1:0], start[4:0]}
    logic [4:0]   r11_r;        // cursor end raster
    logic [5:0]   r14_r;        // cursor address high
    logic [7:0]   r15_r;        // cursor address low
    logic [4:0]   blink_cnt_r;
    logic         cursor_r;

    logic [13:0]  cursor_addr_s;
    logic [4:0]   start_s;
    cursor_mode_t mode_s;
    logic         hit_s;
    logic [7:0]   bus_out_s;

    // The character-clock enable and the row/line timing pulses do not
    // influence the cursor; they are folded here so they are visibly consumed.
    logic unused_inputs_s;
    assign unused_inputs_s = &{1'b0, video_clock_enable, Horizontal,
                               Horizontal_End, Scanline_End};

    assign cursor_addr_s = {r14_r, r15_r};
    assign start_s       = r10_r[4:0];
    assign mode_s        = cursor_mode_t'(r10_r[6:5]);

    // Register file: independent write strobes, not gated by the character clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r10_r <= 7'd0;
            r11_r <= 5'd0;
            r14_r <= 6'd0;
            r15_r <= 8'd0;
        end else begin
            if (write_cursor_start_register) r10_r <= internal_data_bus_in[6:0];
            if (write_cursor_end_register)   r11_r <= internal_data_bus_in[4:0];
            if (write_cursor_h_register)     r14_r <= internal_data_bus_in[5:0];
            if (write_cursor_l_register)     r15_r <= internal_data_bus_in[7:0];
        end
    end

    // Field counter for the blink: advances once per end-of-field pulse, wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_r <= 5'd0;
        end else if (V_total) begin
            blink_cnt_r <= blink_cnt_r + 5'd1;
        end
    end

    // Comparator: address match and raster inside [start, end]; start > end never matches.
    always_comb begin
        hit_s = 1'b0;
        if ((MA == cursor_addr_s) && (RA >= start_s) && (RA <= r11_r)) begin
            hit_s = blink_gate(mode_s, blink_cnt_r);
        end else begin
            hit_s = 1'b0;
        end
    end

    // Read-back mux for the address registers; the high byte wins if both strobes are set.
    always_comb begin
        bus_out_s = 8'h00;
        if (read_cursor_h_register) begin
            bus_out_s = {2'b00, r14_r};
        end else if (read_cursor_l_register) begin
            bus_out_s = r15_r;
        end else begin
            bus_out_s = 8'h00;
        end
    end

    // Registered cursor output, one clock behind the comparator inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cursor_r <= 1'b0;
        end else begin
            cursor_r <= hit_s;
        end
    end

    assign internal_data_bus_out = bus_out_s;
    assign CURSOR                = cursor_r;

endmodule

// File: tb/tb_kf6845_cursor.sv
// Self-checking bench for kf6845_cursor: directed steps plus a randomized
// phase, checked every clock against an arithmetic reference model.
module tb_kf6845_cursor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        video_clock_enable = 1'b0;
    logic [7:0]  internal_data_bus_in = 8'h00;
    logic [7:0]  internal_data_bus_out;
    logic        write_cursor_start_register = 1'b0;
    logic        write_cursor_end_register = 1'b0;
    logic        write_cursor_h_register = 1'b0;
    logic        write_cursor_l_register = 1'b0;
    logic        read_cursor_h_register = 1'b0;
    logic        read_cursor_l_register = 1'b0;
    logic        Horizontal = 1'b0;
    logic        Horizontal_End = 1'b0;
    logic        V_total = 1'b0;
    logic        Scanline_End = 1'b0;
    logic [4:0]  RA = 5'd0;
    logic [13:0] MA = 14'd0;
    logic        CURSOR;

    kf6845_cursor dut (
        .clock                       (clock),
        .reset                       (reset),
        .video_clock_enable          (video_clock_enable),
        .internal_data_bus_in        (internal_data_bus_in),
        .internal_data_bus_out       (internal_data_bus_out),
        .write_cursor_start_register (write_cursor_start_register),
        .write_cursor_end_register   (write_cursor_end_register),
        .write_cursor_h_register     (write_cursor_h_register),
        .write_cursor_l_register     (write_cursor_l_register),
        .read_cursor_h_register      (read_cursor_h_register),
        .read_cursor_l_register      (read_cursor_l_register),
        .Horizontal                  (Horizontal),
        .Horizontal_End              (Horizontal_End),
        .V_total                     (V_total),
        .Scanline_End                (Scanline_End),
        .RA                          (RA),
        .MA                          (MA),
        .CURSOR                      (CURSOR)
    );

    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;

    // Reference model state, kept as plain integers.
    int m_start = 0, m_end = 0, m_mode = 0, m_ca_hi = 0, m_ca_lo = 0, m_fields = 0;

    // Screen timing generator state (11 chars x 4 lines x 6 rows, enable every other clock).
    bit use_timing = 1'b1;
    bit phase = 1'b0;
    int ch = 0, ln = 0, rw = 0;

    function automatic bit model_gate();
        case (m_mode)
            0: return 1'b1;
            1: return 1'b0;
            2: return ((m_fields / 8) % 2) == 0;
            default: return m_fields < 16;
        endcase
    endfunction

    function automatic bit model_hit(int ma, int ra);
        int ca;
        ca = m_ca_hi * 256 + m_ca_lo;
        return (ma == ca) && (ra >= m_start) && (ra <= m_end) && model_gate();
    endfunction

    function automatic logic [7:0] model_read(bit rh, bit rl);
        if (rh) return 8'(m_ca_hi);
        if (rl) return 8'(m_ca_lo);
        return 8'h00;
    endfunction

    task automatic check_bit(string tag, logic obs, logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(string tag, logic [7:0] obs, logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive timing pulses, predict, clock, update model, check.
    task automatic tick();
        bit exp_c;
        if (use_timing) begin
            phase = ~phase;
            video_clock_enable = phase;
            Horizontal     = phase && (ch == 10);
            Horizontal_End = phase && (ch == 7);
            Scanline_End   = phase && (ch == 10) && (ln == 3);
            V_total        = phase && (ch == 10) && (ln == 3) && (rw == 5);
        end
        exp_c = model_hit(int'(MA), int'(RA));
        @(posedge clock);
        if (write_cursor_start_register) begin
            m_start = internal_data_bus_in & 8'h1F;
            m_mode  = (internal_data_bus_in >> 5) & 3;
        end
        if (write_cursor_end_register) m_end   = internal_data_bus_in & 8'h1F;
        if (write_cursor_h_register)   m_ca_hi = internal_data_bus_in & 8'h3F;
        if (write_cursor_l_register)   m_ca_lo = internal_data_bus_in;
        if (V_total) m_fields = (m_fields + 1) % 32;
        if (use_timing && phase) begin
            ch++;
            if (ch == 11) begin ch = 0; ln++; end
            if (ln == 4)  begin ln = 0; rw++; end
            if (rw == 6)  rw = 0;
        end
        #1;
        check_bit("cursor", CURSOR, exp_c);
    endtask

    task automatic write_reg(int which, logic [7:0] data);
        internal_data_bus_in = data;
        write_cursor_start_register = (which == 10);
        write_cursor_end_register   = (which == 11);
        write_cursor_h_register     = (which == 14);
        write_cursor_l_register     = (which == 15);
        tick();
        write_cursor_start_register = 1'b0;
        write_cursor_end_register   = 1'b0;
        write_cursor_h_register     = 1'b0;
        write_cursor_l_register     = 1'b0;
    endtask

    task automatic check_read(string tag, bit rh, bit rl, logic [7:0] exp);
        read_cursor_h_register = rh;
        read_cursor_l_register = rl;
        #1;
        check_byte(tag, internal_data_bus_out, exp);
        check_byte({tag, "_model"}, internal_data_bus_out, model_read(rh, rl));
        read_cursor_h_register = 1'b0;
        read_cursor_l_register = 1'b0;
    endtask

    task automatic sweep_ra(string tag, int exp_ones);
        int ones;
        ones = 0;
        for (int r = 0; r < 32; r++) begin
            RA = 5'(r);
            tick();
            if (CURSOR === 1'b1) ones++;
        end
        RA = 5'd0;
        tick();
        if (CURSOR === 1'b1) ones++;
        compared++;
        assert (ones == exp_ones) else begin
            mismatched++;
            $error("FAIL %s: observed %0d cursor clocks expected %0d", tag, ones, exp_ones);
        end
    endtask

    task automatic run_fields(int n);
        int target;
        target = 0;
        while (target < n) begin
            tick();
            if (V_total) target++;
        end
    endtask

    initial begin
        // 1: reset state
        #2;
        check_bit("reset_cursor", CURSOR, 1'b0);
        check_byte("reset_bus", internal_data_bus_out, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        check_read("reset_r14", 1'b1, 1'b0, 8'h00);
        check_read("reset_r15", 1'b0, 1'b1, 8'h00);

        // 2: register writes and reads
        write_reg(10, 8'h01);
        write_reg(11, 8'h0A);
        write_reg(14, 8'h0F);
        write_reg(15, 8'h12);
        check_read("read_h", 1'b1, 1'b0, 8'h0F);
        check_read("read_l", 1'b0, 1'b1, 8'h12);
        check_read("read_both", 1'b1, 1'b1, 8'h0F);
        check_read("read_none", 1'b0, 1'b0, 8'h00);
        write_reg(14, 8'hFF);
        check_read("read_h_masked", 1'b1, 1'b0, 8'h3F);
        write_reg(14, 8'h0F);

        // 3: non-blink mode, raster sweep on and off the cursor address
        MA = 14'h0F12;
        sweep_ra("sweep_mode00", 10);
        MA = 14'h0000; sweep_ra("sweep_ma0000", 0);
        MA = 14'h0F11; sweep_ra("sweep_ma0f11", 0);
        MA = 14'h0F13; sweep_ra("sweep_ma0f13", 0);

        // 4: cursor disabled
        write_reg(10, 8'h21);
        MA = 14'h0F12;
        sweep_ra("sweep_mode01", 0);

        // 5: blink modes with the cursor held under the beam
        RA = 5'd1;
        write_reg(10, 8'h41);
        run_fields(32);
        write_reg(10, 8'h61);
        run_fields(64);

        // 6: start > end never matches; bit 7 of R10 ignored
        write_reg(10, 8'h85);
        write_reg(11, 8'h02);
        sweep_ra("sweep_start_gt_end", 0);

        // reset mid-blink clears cursor and field counter at once
        write_reg(10, 8'h41);
        write_reg(11, 8'h0A);
        RA = 5'd1;
        run_fields(3);
        while (CURSOR !== 1'b1 && m_fields < 8) tick();
        #2;
        reset = 1'b1;
        #1;
        check_bit("async_reset_cursor", CURSOR, 1'b0);
        m_start = 0; m_end = 0; m_mode = 0; m_ca_hi = 0; m_ca_lo = 0; m_fields = 0;
        @(negedge clock);
        reset = 1'b0;
        write_reg(14, 8'h0F);
        write_reg(15, 8'h12);
        write_reg(11, 8'h0A);
        write_reg(10, 8'h41);
        run_fields(10);

        // randomized phase: random writes, addresses near the cursor, random field pulses
        use_timing = 1'b0;
        video_clock_enable = 1'b1;
        Horizontal = 1'b0; Horizontal_End = 1'b0; Scanline_End = 1'b0;
        for (int i = 0; i < 600; i++) begin
            int sel;
            internal_data_bus_in        = 8'($urandom);
            write_cursor_start_register = ($urandom_range(0, 9) == 0);
            write_cursor_end_register   = ($urandom_range(0, 9) == 0);
            write_cursor_h_register     = ($urandom_range(0, 15) == 0);
            write_cursor_l_register     = ($urandom_range(0, 15) == 0);
            V_total                     = ($urandom_range(0, 3) == 0);
            RA = 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 3);
            if (sel == 0)      MA = 14'($urandom);
            else if (sel == 1) MA = 14'(m_ca_hi * 256 + m_ca_lo + 1);
            else               MA = 14'(m_ca_hi * 256 + m_ca_lo);
            tick();
            read_cursor_h_register = $urandom_range(0, 1);
            read_cursor_l_register = $urandom_range(0, 1);
            #1;
            check_byte("rand_read", internal_data_bus_out,
                       model_read(read_cursor_h_register, read_cursor_l_register));
            read_cursor_h_register = 1'b0;
            read_cursor_l_register = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
